// File: rtl/alm_cfg_pkg.sv
// Shared types and helpers for the ALM configuration-chain loader.
package alm_cfg_pkg;

  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_WORD_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width able to hold 0..n inclusive, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/alm_cfg_serializer.sv
// Holds one upstream word and presents its bits LSB-first, one per shift.
module alm_cfg_serializer
  import alm_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              clear_sync,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_bit,
  output logic              o_last_bit
);

  localparam int IW = cnt_w(WORD_W);

  logic [WORD_W-1:0] r_word;
  logic [IW-1:0]     r_idx;

  // Word register is pure data: it is always reloaded before being used.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_word <= i_word;
    end else if (i_shift) begin
      r_word <= r_word >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_sync) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_idx <= '0;
    end else if (i_shift && !o_last_bit) begin
      r_idx <= r_idx + IW'(1);
    end
  end

  assign o_bit      = r_word[0];
  assign o_last_bit = (r_idx == IW'(WORD_W - 1));

endmodule

// File: rtl/alm_config_loader.sv
// Serial config-chain loader for one ALM tile with a non-destructive
// rotate-and-popcount verify pass.
module alm_config_loader
  import alm_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic                           clk,
  input  logic                           clear_sync,
  input  logic                           start_load,
  input  logic                           start_verify,
  input  logic [WORD_W-1:0]              word_data,
  input  logic                           word_valid,
  output logic                           word_ready,
  output logic                           config_in,
  output logic                           config_en,
  input  logic                           config_out,
  output logic                           busy,
  output logic                           done,
  output logic                           match,
  output logic [$clog2(CHAIN_LEN+1)-1:0] ones_loaded
);

  localparam int CW = cnt_w(CHAIN_LEN);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] r_vcnt;
  logic [CW-1:0] r_ones;
  logic          r_match;

  logic          w_load;
  logic          w_shift;
  logic          w_ser_bit;
  logic          w_ser_last;
  logic          w_term;
  logic [CW-1:0] w_vcnt_nxt;

  alm_cfg_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk        (clk),
    .clear_sync (clear_sync),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_word     (word_data),
    .o_bit      (w_ser_bit),
    .o_last_bit (w_ser_last)
  );

  assign w_term     = (r_bit_cnt == CW'(CHAIN_LEN - 1));
  assign w_vcnt_nxt = r_vcnt + CW'(config_out);

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_load) begin
          w_next = ST_FETCH;
        end else if (start_verify) begin
          w_next = ST_VERIFY;
        end
      end
      ST_FETCH: begin
        if (word_valid) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_term) begin
          w_next = ST_DONE;
        end else if (w_ser_last) begin
          w_next = ST_FETCH;
        end
      end
      ST_VERIFY: begin
        if (w_term) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // In VERIFY the chain output is looped straight back so the chain rotates.
  always_comb begin
    word_ready = 1'b0;
    config_en  = 1'b0;
    config_in  = 1'b0;
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_DONE);
    case (r_state)
      ST_FETCH:  word_ready = 1'b1;
      ST_SHIFT: begin
        config_en = 1'b1;
        config_in = w_ser_bit;
      end
      ST_VERIFY: begin
        config_en = 1'b1;
        config_in = config_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_sync) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_vcnt    <= '0;
      r_ones    <= '0;
      r_match   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start_load) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
            r_match   <= 1'b0;
          end else if (start_verify) begin
            r_bit_cnt <= '0;
            r_vcnt    <= '0;
            r_match   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_ones <= r_ones + CW'(w_ser_bit);
          if (!w_term) begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        ST_VERIFY: begin
          r_vcnt <= w_vcnt_nxt;
          if (!w_term) begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end else begin
            r_match <= (w_vcnt_nxt == r_ones);
          end
        end
        default: ;
      endcase
    end
  end

  assign match       = r_match;
  assign ones_loaded = r_ones;

endmodule

// File: tb/tb_alm_config_loader.sv
// Directed bench for alm_config_loader with a 20-bit behavioural chain.
module tb_alm_config_loader;
  import alm_cfg_pkg::*;

  localparam int CL     = 20;
  localparam int WW     = 8;
  localparam int NWORDS = ceil_div(CL, WW);

  logic          clk;
  logic          clear_sync;
  logic          start_load;
  logic          start_verify;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          config_in;
  logic          config_en;
  logic          config_out;
  logic          busy;
  logic          done;
  logic          match;
  logic [4:0]    ones_loaded;

  logic [CL-1:0] chain = '0;
  logic          corrupt = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  alm_config_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW)
  ) dut (
    .clk          (clk),
    .clear_sync   (clear_sync),
    .start_load   (start_load),
    .start_verify (start_verify),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .config_in    (config_in),
    .config_en    (config_en),
    .config_out   (config_out),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .ones_loaded  (ones_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chain[0] is the first flop (fed by config_in), chain[CL-1] drives config_out.
  always @(posedge clk) begin
    if (corrupt) begin
      chain[5] <= ~chain[5];
    end else if (config_en) begin
      chain <= {chain[CL-2:0], config_in};
    end
  end
  assign config_out = chain[CL-1];

  typedef struct {
    int         gap;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] w2;
    logic [19:0] bits;
    int         ones;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] rev20(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 20; i++) r[19-i] = b[i];
    return r;
  endfunction

  // Runs one load from IDLE; returns at the negedge of the done cycle.
  task automatic do_load(input int gap, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input bit both, input int sv_at,
                         input int clr_at, output logic [19:0] bits, output int nen,
                         output int nready, output int nhs, output int ncyc,
                         output int nbusy_lo, output bit tmo, output bit cleared);
    logic [7:0] w[3];
    int widx;
    int g;
    bit hs;
    bit fin;
    w[0] = w0; w[1] = w1; w[2] = w2;
    bits = '0; nen = 0; nready = 0; nhs = 0; ncyc = 0; nbusy_lo = 0;
    tmo = 1'b0; cleared = 1'b0; widx = 0; g = 0; hs = 1'b0; fin = 1'b0;
    start_load = 1'b1;
    start_verify = both;
    @(negedge clk);
    start_load = 1'b0;
    start_verify = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      if (done) begin
        ncyc = c;
        fin = 1'b1;
      end else begin
        if (!busy) nbusy_lo++;
        if (config_en) begin
          if (nen < 20) bits[nen] = config_in;
          nen++;
        end
        if (clr_at >= 0 && config_en && nen == clr_at) begin
          clear_sync = 1'b1;
          word_valid = 1'b0;
          @(negedge clk);
          clear_sync = 1'b0;
          cleared = 1'b1;
          fin = 1'b1;
        end else begin
          start_verify = (sv_at >= 0 && config_en && nen == sv_at);
          if (word_ready) begin
            nready++;
            if (g < gap) begin
              word_valid = 1'b0;
              g++;
            end else begin
              word_valid = 1'b1;
              word_data = (widx < 3) ? w[widx] : 8'h00;
              hs = 1'b1;
            end
          end else begin
            word_valid = (gap == 0);
            word_data = (widx < 3) ? w[widx] : 8'hFF;
          end
          @(negedge clk);
          if (hs) begin
            widx++;
            nhs++;
            g = 0;
            hs = 1'b0;
          end
        end
      end
    end
    tmo = !fin;
    word_valid = 1'b0;
    start_verify = 1'b0;
  endtask

  task automatic do_verify(output int nen, output int ncyc, output logic m, output bit tmo);
    bit fin;
    nen = 0; ncyc = 0; m = 1'b0; fin = 1'b0;
    start_verify = 1'b1;
    @(negedge clk);
    start_verify = 1'b0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      if (done) begin
        m = match;
        ncyc = c;
        fin = 1'b1;
      end else begin
        if (config_en) nen++;
        @(negedge clk);
      end
    end
    tmo = !fin;
  endtask

  logic [19:0] bits;
  logic [19:0] snap;
  int nen, nready, nhs, ncyc, nbl;
  bit tmo, clr;
  logic m;

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h3C, 8'hF9, 20'h93CA5, 10};
    vecs[1] = '{5, 8'hA5, 8'h3C, 8'hF9, 20'h93CA5, 10};
    vecs[2] = '{0, 8'hFF, 8'hFF, 8'hFF, 20'hFFFFF, 20};
    vecs[3] = '{2, 8'h01, 8'h80, 8'hF5, 20'h58001, 4};

    clear_sync = 1'b1; start_load = 1'b0; start_verify = 1'b0;
    word_data = '0; word_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, busy, done, word_ready, config_en, config_in, match}, 32'd0);
    chk("reset_ones", ones_loaded, 0);
    clear_sync = 1'b0;
    @(negedge clk);

    // Verify before any load compares against ones_loaded=0 on an empty chain.
    do_verify(nen, ncyc, m, tmo);
    chk("noload_verify_timeout", tmo, 0);
    chk("noload_verify_en", nen, CL);
    chk("noload_verify_match", m, 1);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_load(vecs[i].gap, vecs[i].w0, vecs[i].w1, vecs[i].w2, 1'b0, -1, -1,
              bits, nen, nready, nhs, ncyc, nbl, tmo, clr);
      chk($sformatf("v%0d_timeout", i), tmo, 0);
      chk($sformatf("v%0d_bits", i), bits, vecs[i].bits);
      chk($sformatf("v%0d_en_cycles", i), nen, CL);
      chk($sformatf("v%0d_handshakes", i), nhs, NWORDS);
      chk($sformatf("v%0d_ready_cycles", i), nready, NWORDS * (vecs[i].gap + 1));
      chk($sformatf("v%0d_done_cycle", i), ncyc, NWORDS * (vecs[i].gap + 1) + CL + 1);
      chk($sformatf("v%0d_busy_low", i), nbl, 0);
      chk($sformatf("v%0d_ones", i), ones_loaded, vecs[i].ones);
      chk($sformatf("v%0d_chain", i), chain, rev20(vecs[i].bits));
      @(negedge clk);
      chk($sformatf("v%0d_after_done", i), {busy, done}, 0);
      snap = chain;
      do_verify(nen, ncyc, m, tmo);
      chk($sformatf("v%0d_verify_timeout", i), tmo, 0);
      chk($sformatf("v%0d_verify_en", i), nen, CL);
      chk($sformatf("v%0d_verify_match", i), m, 1);
      chk($sformatf("v%0d_verify_chain", i), chain, snap);
      @(negedge clk);
      chk($sformatf("v%0d_match_hold", i), match, 1);
    end

    // Flip one chain bit: popcount no longer agrees.
    corrupt = 1'b1;
    @(negedge clk);
    corrupt = 1'b0;
    do_verify(nen, ncyc, m, tmo);
    chk("corrupt_verify_timeout", tmo, 0);
    chk("corrupt_verify_match", m, 0);
    @(negedge clk);

    // Both starts together: load only.
    do_load(0, 8'hA5, 8'h3C, 8'hF9, 1'b1, -1, -1, bits, nen, nready, nhs, ncyc, nbl, tmo, clr);
    chk("both_timeout", tmo, 0);
    chk("both_bits", bits, 20'h93CA5);
    chk("both_ones", ones_loaded, 10);
    chk("both_done_cycle", ncyc, 24);
    @(negedge clk);
    chk("both_no_verify", {busy, config_en}, 0);
    repeat (3) @(negedge clk);
    chk("both_still_idle", {busy, config_en, done}, 0);

    // start_verify in the middle of SHIFT is ignored.
    do_load(0, 8'hA5, 8'h3C, 8'hF9, 1'b0, 5, -1, bits, nen, nready, nhs, ncyc, nbl, tmo, clr);
    chk("svshift_timeout", tmo, 0);
    chk("svshift_busy_low", nbl, 0);
    chk("svshift_done_cycle", ncyc, 24);
    chk("svshift_bits", bits, 20'h93CA5);
    @(negedge clk);
    chk("svshift_single_done", {busy, done}, 0);
    repeat (2) @(negedge clk);
    chk("svshift_no_second_done", {busy, done}, 0);

    // clear_sync in the second word, then a full reload.
    do_load(0, 8'hA5, 8'h3C, 8'hF9, 1'b0, -1, 10, bits, nen, nready, nhs, ncyc, nbl, tmo, clr);
    chk("clr_taken", clr, 1);
    chk("clr_outputs", {busy, word_ready, config_en, done, match}, 0);
    chk("clr_ones", ones_loaded, 0);
    @(negedge clk);
    do_load(0, 8'hA5, 8'h3C, 8'hF9, 1'b0, -1, -1, bits, nen, nready, nhs, ncyc, nbl, tmo, clr);
    chk("reload_timeout", tmo, 0);
    chk("reload_bits", bits, 20'h93CA5);
    chk("reload_ones", ones_loaded, 10);
    @(negedge clk);
    do_verify(nen, ncyc, m, tmo);
    chk("reload_verify_timeout", tmo, 0);
    chk("reload_verify_match", m, 1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alm_config_loader.md
# alm_config_loader

Loads the serial configuration chain of one registered ALM tile from a word-wide upstream stream, then optionally reads it back non-destructively. Sits directly upstream of the tile's `config_in`/`config_en`/`config_out` ports. It serialises words onto the chain and counts the ones written. A verify pass rotates the chain once and compares its ones-count with the loaded count. The tile's `config_clk` is tied to this block's `clk` at the top level.

## Interface
Parameters:
- `CHAIN_LEN`, 64: number of config bits in the ALM chain (≥1).
- `WORD_W`, 8: upstream word width (≥1). Words needed: `NWORDS = ceil(CHAIN_LEN/WORD_W)`.

Ports:
- `clk`  in  1  single clock, also drives the tile's `config_clk`.
- `clear_sync`  in  1  reset; synchronous, active-high.
- `start_load`  in  1  command pulse, sampled only in IDLE.
- `start_verify`  in  1  command pulse, sampled only in IDLE.
- `word_data`  in  WORD_W  config word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  block accepts a word this cycle.
- `config_in`  out  1  to tile `config_in`.
- `config_en`  out  1  to tile `config_en`; high for exactly one cycle per shifted bit.
- `config_out`  in  1  from tile `config_out` (last chain flop).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a load or verify completes.
- `match`  out  1  result of the last verify; meaningful from its `done` until the next start.
- `ones_loaded`  out  clog2(CHAIN_LEN+1)  popcount of the bits written by the last load.

## Operation
- Reset values: all outputs 0, `ones_loaded`=0, state IDLE.
- FSM states:
  - IDLE.
  - FETCH: `word_ready`=1, `config_en`=0. Stays until `word_valid`. Captures the word and moves to SHIFT.
  - SHIFT: shifts word bits LSB-first, one per cycle with `config_en`=1. Adds each bit to the ones counter.
    - Leaves after WORD_W bits, or after the remaining bits if fewer remain (the last word may be partial; its upper bits are ignored).
    - Goes to FETCH if chain bits remain, else to DONE.
  - VERIFY: `config_en`=1 for exactly CHAIN_LEN consecutive cycles. `config_in`=`config_out` combinationally, so the chain rotates back to its original contents. Counts ones seen on `config_out`, then goes to DONE.
  - DONE: one cycle with `done`=1, then returns to IDLE.
- `start_load` in IDLE: clears the bit counter and `ones_loaded`, then goes to FETCH.
- `start_verify` in IDLE: clears the verify counter, then goes to VERIFY. At DONE, `match` = (verify count == `ones_loaded`).
- Both starts high in IDLE: load wins, verify is dropped.
- Starts while `busy` are ignored.
- `word_valid` outside FETCH is ignored; no word is consumed.
- In SHIFT, `config_in` is the registered current bit. In VERIFY it is combinational from `config_out`. Otherwise it is 0.
- Verify without a prior load compares against `ones_loaded`=0.
- `clear_sync` mid-operation: returns to IDLE next edge and zeros all outputs. Chain contents are undefined (partial load); upstream must restart the whole stream.

## Timing
- Start sampled at edge N → state entered at N+1.
- Load, valid held high: exactly NWORDS FETCH cycles plus CHAIN_LEN SHIFT cycles, then one DONE cycle.
  - A word handshake at edge M → its first bit has `config_en`=1 in cycle M+1.
- Verify: CHAIN_LEN cycles of `config_en`, then DONE.
  - `match` updates on the DONE cycle and holds until the next start.
- Bit counter: 0..CHAIN_LEN-1, no wrap. Terminal count triggers the exit from SHIFT/VERIFY.

## Structure
- Shared package `alm_cfg_pkg` holds:
  - the state enum (IDLE, FETCH, SHIFT, VERIFY, DONE);
  - the `ceil_div` and counter-width functions;
  - the default constants for `CHAIN_LEN` and `WORD_W`.
- One sub-module, `alm_cfg_serializer`. It holds the word register and in-word bit index, and provides `load`, `shift`, `bit`, and `last_bit` outputs. The FSM, counters and compare stay in the top level.

## Test plan
All scenarios use CHAIN_LEN=20, WORD_W=8 (NWORDS=3).
- Load 0xA5, 0x3C, 0xF9 with valid held high → `config_in` bits 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0 / 1,0,0,1. `config_en` high for 20 cycles total, 3 ready cycles, `ones_loaded`=10, `done` 24 cycles after FETCH entry.
- Same load with 5 idle cycles between words → identical `config_in` bit sequence, `config_en` low during the gaps, same `ones_loaded`.
- Verify after that load with a behavioural 20-bit chain model → 20 `config_en` cycles, chain contents unchanged, `match`=1. Then corrupt one chain bit and verify again → `match`=0.
- `start_load` and `start_verify` in the same cycle → load performed, no verify pass. A `start_verify` pulse during SHIFT → ignored, `busy` stays high, a single `done`.
- `clear_sync` during the second word → next cycle: IDLE, `word_ready`=0, `config_en`=0, `ones_loaded`=0. A fresh full load then succeeds and verify gives `match`=1.
